// File: rtl/collision_pkg.sv
// Shared encodings and default geometry for the collision engine and the
// tube/bird position generators.
package collision_pkg;

    localparam int DEF_W          = 10;
    localparam int DEF_NUM_TUBES  = 3;
    localparam int DEF_BIRD_X     = 225;
    localparam int DEF_BIRD_W     = 25;
    localparam int DEF_BIRD_H     = 25;
    localparam int DEF_TUBE_W     = 100;
    localparam int DEF_GAP_H      = 100;
    localparam int DEF_SCREEN_H   = 480;
    localparam int DEF_TOP_MARGIN = 1;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_TUBE  = 2'd1,
        CAUSE_CEIL  = 2'd2,
        CAUSE_FLOOR = 2'd3
    } cause_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_BOUNDS = 2'd2,
        ST_REPORT = 2'd3
    } state_e;

    // Width of a tube index; a single-tube build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tube_hit_check.sv
// Combinational bird-versus-one-tube test. All sums carry one extra bit so
// tubes near the right screen edge never wrap into the bird's column.
module tube_hit_check #(
    parameter int W      = 10,
    parameter int BIRD_X = 225,
    parameter int BIRD_W = 25,
    parameter int BIRD_H = 25,
    parameter int TUBE_W = 100,
    parameter int GAP_H  = 100
) (
    input  logic [W-1:0] tube_x,
    input  logic [W-1:0] tube_y,
    input  logic [W-1:0] bird_y,
    output logic         hit
);

    logic [W:0] w_tube_x;
    logic [W:0] w_tube_y;
    logic [W:0] w_bird_y;
    logic       w_overlap;
    logic       w_outside_gap;

    assign w_tube_x = {1'b0, tube_x};
    assign w_tube_y = {1'b0, tube_y};
    assign w_bird_y = {1'b0, bird_y};

    assign w_overlap = (w_tube_x < (W+1)'(BIRD_X + BIRD_W)) &&
                       ((w_tube_x + (W+1)'(TUBE_W)) > (W+1)'(BIRD_X));

    assign w_outside_gap = (w_bird_y < w_tube_y) ||
                           ((w_bird_y + (W+1)'(BIRD_H)) > (w_tube_y + (W+1)'(GAP_H)));

    assign hit = w_overlap && w_outside_gap;

endmodule

// File: rtl/collision_engine.sv
// Per-frame collision evaluator: snapshots positions on frame_tick, scans one
// tube per cycle, checks ceiling/floor, then reports a sticky first cause.
module collision_engine
    import collision_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int NUM_TUBES  = DEF_NUM_TUBES,
    parameter int BIRD_X     = DEF_BIRD_X,
    parameter int BIRD_W     = DEF_BIRD_W,
    parameter int BIRD_H     = DEF_BIRD_H,
    parameter int TUBE_W     = DEF_TUBE_W,
    parameter int GAP_H      = DEF_GAP_H,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int TOP_MARGIN = DEF_TOP_MARGIN
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              frame_tick,
    input  logic                              clear,
    input  logic [NUM_TUBES*W-1:0]            tube_x,
    input  logic [NUM_TUBES*W-1:0]            tube_y,
    input  logic [W-1:0]                      bird_y,
    output logic                              busy,
    output logic                              done,
    output logic                              lose,
    output logic [1:0]                        hit_cause,
    output logic [idx_width(NUM_TUBES)-1:0]   hit_tube,
    output logic                              overrun
);

    localparam int             IW       = idx_width(NUM_TUBES);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_TUBES - 1);

    state_e          r_state;
    logic [W-1:0]    r_tx [NUM_TUBES];
    logic [W-1:0]    r_ty [NUM_TUBES];
    logic [W-1:0]    r_by;
    logic [IW-1:0]   r_idx;
    logic            r_frame_hit;
    logic [IW-1:0]   r_frame_tube;
    logic            r_busy;
    logic            r_done;
    logic            r_lose;
    cause_e          r_cause;
    logic [IW-1:0]   r_tube;
    logic            r_overrun;

    logic            w_tube_hit;
    logic            w_ceil;
    logic            w_floor;
    cause_e          w_final_cause;
    logic [IW-1:0]   w_final_tube;

    tube_hit_check #(
        .W      (W),
        .BIRD_X (BIRD_X),
        .BIRD_W (BIRD_W),
        .BIRD_H (BIRD_H),
        .TUBE_W (TUBE_W),
        .GAP_H  (GAP_H)
    ) u_tube_hit_check (
        .tube_x (r_tx[r_idx]),
        .tube_y (r_ty[r_idx]),
        .bird_y (r_by),
        .hit    (w_tube_hit)
    );

    assign w_ceil  = ({1'b0, r_by} <= (W+1)'(TOP_MARGIN));
    assign w_floor = (({1'b0, r_by} + (W+1)'(BIRD_H)) >= (W+1)'(SCREEN_H - 1));

    // Resolve the frame's cause: lowest tube hit, then ceiling, then floor.
    always_comb begin
        w_final_cause = CAUSE_NONE;
        w_final_tube  = '0;
        if (r_frame_hit) begin
            w_final_cause = CAUSE_TUBE;
            w_final_tube  = r_frame_tube;
        end else if (w_ceil) begin
            w_final_cause = CAUSE_CEIL;
        end else if (w_floor) begin
            w_final_cause = CAUSE_FLOOR;
        end else begin
            w_final_cause = CAUSE_NONE;
        end
    end

    // Evaluation FSM with snapshot, scan accumulator and sticky result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            for (int i = 0; i < NUM_TUBES; i++) begin
                r_tx[i] <= '0;
                r_ty[i] <= '0;
            end
            r_by         <= '0;
            r_idx        <= '0;
            r_frame_hit  <= 1'b0;
            r_frame_tube <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_lose       <= 1'b0;
            r_cause      <= CAUSE_NONE;
            r_tube       <= '0;
            r_overrun    <= 1'b0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_frame_hit  <= 1'b0;
            r_frame_tube <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_lose       <= 1'b0;
            r_cause      <= CAUSE_NONE;
            r_tube       <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (frame_tick && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (frame_tick) begin
                        for (int i = 0; i < NUM_TUBES; i++) begin
                            r_tx[i] <= tube_x[i*W +: W];
                            r_ty[i] <= tube_y[i*W +: W];
                        end
                        r_by         <= bird_y;
                        r_idx        <= '0;
                        r_frame_hit  <= 1'b0;
                        r_frame_tube <= '0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (w_tube_hit && !r_frame_hit) begin
                        r_frame_hit  <= 1'b1;
                        r_frame_tube <= r_idx;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_BOUNDS;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                ST_BOUNDS: begin
                    // Result and done land together on entry to REPORT.
                    r_done  <= 1'b1;
                    r_state <= ST_REPORT;
                    if (!r_lose && (w_final_cause != CAUSE_NONE)) begin
                        r_lose  <= 1'b1;
                        r_cause <= w_final_cause;
                        r_tube  <= w_final_tube;
                    end
                end
                ST_REPORT: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign lose      = r_lose;
    assign hit_cause = r_cause;
    assign hit_tube  = r_tube;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_collision_engine.sv
// Randomized and directed bench for collision_engine against a geometric
// reference model of the collision rules.
module tb_collision_engine;

    localparam int W  = 10;
    localparam int NT = 3;
    localparam int BIRD_X = 225, BIRD_W = 25, BIRD_H = 25;
    localparam int TUBE_W = 100, GAP_H = 100, SCREEN_H = 480, TOP_MARGIN = 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              frame_tick;
    logic              clear;
    logic [NT*W-1:0]   tube_x;
    logic [NT*W-1:0]   tube_y;
    logic [W-1:0]      bird_y;
    logic              busy, done, lose, overrun;
    logic [1:0]        hit_cause;
    logic [1:0]        hit_tube;

    int n_chk = 0;
    int n_err = 0;
    int m_lose, m_cause, m_tube, m_overrun;

    collision_engine #(
        .W(W), .NUM_TUBES(NT), .BIRD_X(BIRD_X), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H),
        .TUBE_W(TUBE_W), .GAP_H(GAP_H), .SCREEN_H(SCREEN_H), .TOP_MARGIN(TOP_MARGIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .clear(clear),
        .tube_x(tube_x), .tube_y(tube_y), .bird_y(bird_y),
        .busy(busy), .done(done), .lose(lose), .hit_cause(hit_cause),
        .hit_tube(hit_tube), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // First-cause rules over the whole frame, plain integer geometry.
    function automatic void model_eval(input int tx[NT], input int ty[NT], input int by,
                                       output int cause, output int tube);
        cause = 0;
        tube  = 0;
        for (int i = 0; i < NT; i++) begin
            if (cause == 0 && tx[i] < BIRD_X + BIRD_W && tx[i] + TUBE_W > BIRD_X &&
                (by < ty[i] || by + BIRD_H > ty[i] + GAP_H)) begin
                cause = 1;
                tube  = i;
            end
        end
        if (cause == 0 && by <= TOP_MARGIN) cause = 2;
        else if (cause == 0 && by + BIRD_H >= SCREEN_H - 1) cause = 3;
    endfunction

    task automatic drive_pos(input int tx[NT], input int ty[NT], input int by);
        for (int i = 0; i < NT; i++) begin
            tube_x[i*W +: W] = W'(tx[i]);
            tube_y[i*W +: W] = W'(ty[i]);
        end
        bird_y = W'(by);
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".lose"}, int'(lose), m_lose);
        check_val({tag, ".cause"}, int'(hit_cause), m_cause);
        check_val({tag, ".tube"}, int'(hit_tube), m_tube);
        check_val({tag, ".overrun"}, int'(overrun), m_overrun);
    endtask

    task automatic run_frame(input int tx[NT], input int ty[NT], input int by, input string tag);
        int cause, tube, lat;
        bit seen;
        drive_pos(tx, ty, by);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        model_eval(tx, ty, by, cause, tube);
        if (m_lose == 0 && cause != 0) begin
            m_lose  = 1;
            m_cause = cause;
            m_tube  = tube;
        end
        lat  = 1;
        seen = 1'b0;
        while (lat <= 20) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tube_x = (NT*W)'({$urandom, $urandom});
            tube_y = (NT*W)'({$urandom, $urandom});
            bird_y = W'($urandom);
            step();
            lat++;
        end
        if (!seen) check_val({tag, ".done_timeout"}, 0, 1);
        else       check_val({tag, ".latency"}, lat, NT + 2);
        check_outputs(tag);
        check_val({tag, ".busy_report"}, int'(busy), 1);
        step();
        check_val({tag, ".done_pulse"}, int'(done), 0);
        check_val({tag, ".busy_idle"}, int'(busy), 0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        m_lose = 0; m_cause = 0; m_tube = 0; m_overrun = 0;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        int n_done, n_busy;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < cycles; i++) begin
            if (done) n_done++;
            if (busy) n_busy++;
            step();
        end
        check_val({tag, ".no_done"}, n_done, 0);
        check_val({tag, ".no_busy"}, n_busy, 0);
    endtask

    initial begin
        int ax[NT], ay[NT];
        int n_done;
        rst_n = 1'b0; frame_tick = 1'b0; clear = 1'b0;
        tube_x = '0; tube_y = '0; bird_y = '0;
        m_lose = 0; m_cause = 0; m_tube = 0; m_overrun = 0;
        repeat (3) step();
        check_val("rst.busy", int'(busy), 0);
        check_val("rst.done", int'(done), 0);
        check_outputs("rst");
        rst_n = 1'b1;
        step();

        ax = '{230, 400, 600}; ay = '{150, 0, 0};
        run_frame(ax, ay, 180, "safe");

        ax = '{900, 240, 600}; ay = '{0, 200, 0};
        run_frame(ax, ay, 100, "tube_hit");
        check_val("tube_hit.idx_literal", int'(hit_tube), 1);
        run_frame(ax, ay, 470, "sticky");
        check_val("sticky.cause_literal", int'(hit_cause), 1);

        // Asynchronous reset two cycles into a scan.
        drive_pos(ax, ay, 100);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        m_lose = 0; m_cause = 0; m_tube = 0; m_overrun = 0;
        check_val("rst_mid.busy", int'(busy), 0);
        check_val("rst_mid.done", int'(done), 0);
        check_outputs("rst_mid");
        step();
        rst_n = 1'b1;
        expect_quiet("rst_mid", 8);

        ax = '{230, 900, 900}; ay = '{0, 0, 0};
        run_frame(ax, ay, 1, "ceil");
        pulse_clear();
        check_val("clear.lose", int'(lose), 0);
        ax = '{900, 900, 900};
        run_frame(ax, ay, 454, "floor");
        pulse_clear();

        ax = '{1000, 1000, 1000};
        run_frame(ax, ay, 300, "wrap");

        // Back-to-back ticks: the second one only flags overrun.
        ax = '{900, 240, 600}; ay = '{0, 200, 0};
        drive_pos(ax, ay, 100);
        frame_tick = 1'b1;
        step();
        step();
        frame_tick = 1'b0;
        n_done = 0;
        for (int i = 0; i < 15; i++) begin
            if (done) n_done++;
            step();
        end
        m_lose = 1; m_cause = 1; m_tube = 1; m_overrun = 1;
        check_val("overrun.dones", n_done, 1);
        check_outputs("overrun");

        clear = 1'b1;
        frame_tick = 1'b1;
        step();
        clear = 1'b0;
        frame_tick = 1'b0;
        m_lose = 0; m_cause = 0; m_tube = 0; m_overrun = 0;
        check_outputs("clear_tick");
        expect_quiet("clear_tick", 8);

        // Clear in the middle of a scan aborts it silently.
        drive_pos(ax, ay, 100);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        pulse_clear();
        check_outputs("clear_mid");
        expect_quiet("clear_mid", 8);

        for (int f = 0; f < 40; f++) begin
            for (int i = 0; i < NT; i++) begin
                ax[i] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(100, 300))
                                                    : int'($urandom_range(0, 1023));
                ay[i] = int'($urandom_range(0, 420));
            end
            if ($urandom_range(0, 3) == 0) pulse_clear();
            run_frame(ax, ay, int'($urandom_range(0, 479)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/collision_engine.md
Name: collision_engine

Overview:
- Parametrised, sequential successor to the combinational bird/tube collision check.
- On each frame strobe it snapshots all tube positions and the bird height, then scans the tubes one per cycle and checks the screen bounds.
- Raises a sticky lose flag, reports the cause and the tube index, and pulses done.
- Sits between the tube/bird position generators and the game-state controller; evaluates once per frame, during vertical blank.

Parameters:
- W, 10, coordinate width in bits.
- NUM_TUBES, 3, number of tube channels (1..16).
- BIRD_X, 225, bird left edge (x).
- BIRD_W, 25, bird width.
- BIRD_H, 25, bird height.
- TUBE_W, 100, tube width.
- GAP_H, 100, vertical gap height; the gap starts at tube_y.
- SCREEN_H, 480, screen height in lines.
- TOP_MARGIN, 1, bird_y at or below this value is a ceiling hit.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- frame_tick, in, 1, one-cycle strobe that starts an evaluation.
- clear, in, 1, one-cycle strobe that clears the sticky result (game restart).
- tube_x, in, NUM_TUBES*W, packed tube left edges; tube i is bits [i*W +: W].
- tube_y, in, NUM_TUBES*W, packed gap top edges, same packing.
- bird_y, in, W, bird top edge.
- busy, out, 1, evaluation in progress.
- done, out, 1, one-cycle pulse when an evaluation completes.
- lose, out, 1, sticky collision flag.
- hit_cause, out, 2, 0 none / 1 tube / 2 ceiling / 3 floor.
- hit_tube, out, $clog2(NUM_TUBES) (min 1), index of the tube that caused the hit.
- overrun, out, 1, sticky flag: a frame_tick arrived while busy.

Behaviour:
- Reset (rst_n low, asynchronous): FSM to IDLE; busy, done, lose, overrun = 0; hit_cause = 0; hit_tube = 0; snapshot registers = 0.
- FSM states: IDLE, SCAN, BOUNDS, REPORT.
- IDLE: on frame_tick (and not clear), latch tube_x, tube_y and bird_y into snapshot registers; idx = 0; go to SCAN.
- SCAN: evaluate tube idx once per cycle.
  - idx increments each cycle.
  - After idx = NUM_TUBES-1, go to BOUNDS.
- BOUNDS: evaluate ceiling and floor in one cycle; go to REPORT.
- REPORT: assert done for one cycle; update lose, hit_cause and hit_tube; return to IDLE.
- busy is high in SCAN, BOUNDS and REPORT.
- Latency: done asserts NUM_TUBES+2 cycles after the frame_tick cycle (5 cycles with defaults).
- Tube overlap test: tube_x < BIRD_X+BIRD_W AND tube_x+TUBE_W > BIRD_X.
- Tube hit: overlap AND (bird_y < tube_y OR bird_y+BIRD_H > tube_y+GAP_H).
- Ceiling hit: bird_y <= TOP_MARGIN.
- Floor hit: bird_y+BIRD_H >= SCREEN_H-1.
- Arithmetic: every sum is computed at W+1 bits; no wraparound. Example: tube_x=1000 with TUBE_W=100 gives 1100, not 76.
- All tubes and both bounds are evaluated on every frame, whether or not any tube overlaps the bird.
- Cause priority within one frame: lowest-index tube hit, then ceiling, then floor.
- Result capture:
  - If lose is 0 and the frame found a hit: set lose = 1 and load hit_cause and hit_tube.
  - Once lose = 1, later frames never change hit_cause or hit_tube; the first cause is retained.
  - A frame with no hit leaves all outputs unchanged.
- hit_tube is 0 whenever hit_cause is not 1.
- frame_tick while busy: ignored (no restart) and sets overrun.
- clear, in any state:
  - Synchronously zeroes lose, hit_cause, hit_tube and overrun.
  - Aborts any scan in progress; FSM returns to IDLE and no done pulse is produced.
  - clear and frame_tick in the same cycle: clear wins and the tick is dropped.
- Inputs are changed freely during a scan; only the snapshot is used.
- NUM_TUBES=1: SCAN lasts one cycle.

Decomposition:
- Shared package collision_pkg holds:
  - the hit_cause encodings (CAUSE_NONE, CAUSE_TUBE, CAUSE_CEIL, CAUSE_FLOOR);
  - the FSM state encoding;
  - the default geometry constants, shared with the tube and bird generators.
- One sub-module, tube_hit_check: combinational; takes one tube_x, tube_y and bird_y plus the geometry parameters; outputs hit. It is instantiated once and time-multiplexed by idx.

Test Plan:
- Reset mid-scan: pulse frame_tick, drop rst_n on cycle 2 -> all outputs 0 immediately, FSM IDLE, no done pulse.
- Safe pass:
  - Stimulus: tube_x={600,400,230}, tube_y={0,0,150}, bird_y=180, one frame_tick.
  - Response: done exactly 5 cycles later; lose=0; hit_cause=0.
- Tube hit:
  - Stimulus: tube_x={600,240,900}, tube_y={0,200,0}, bird_y=100.
  - Response: lose=1, hit_cause=1, hit_tube=1.
  - Then a second frame with bird_y=470 -> hit_cause stays 1 (sticky first cause).
- Bounds with tube overlap:
  - Stimulus: tube 0 at x=230, y=0 (bird inside the gap); bird_y=1.
  - Response: hit_cause=2 (ceiling checked despite the overlap).
  - With bird_y=454 and no tube overlap -> hit_cause=3.
- Wrap check: tube_x=1000, tube_y=0, bird_y=300 -> no tube hit (1000+100 evaluated at 11 bits); lose=0.
- Overrun and clear:
  - Stimulus: frame_tick on two consecutive cycles.
  - Response: overrun=1 and a single done.
  - Then clear asserted together with frame_tick -> lose, overrun and hit_cause all 0; FSM stays IDLE; no done.
